// File: rtl/vram_port_arbiter_if.sv
// vram_port_arbiter_if: requester and DDR2 command-port signals for vram_port_arbiter.
//   calib_done            memory calibration complete
//   rd_req/addr/bl/ack    read (scanout) requester handshake, bl = burst length - 1
//   wr_req/addr/bl/ack    write (render) requester handshake, wr_count = words in write FIFO
//   cmd_full/en/instr/bl/byte_addr  MCB command port
//   starve_cnt            debug view of the write starvation counter
//   slave modport: arbiter side; master modport: requesters/memory side.
interface vram_port_arbiter_if #(parameter int ADDR_W = 30);
    logic              calib_done;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [5:0]        rd_bl;
    logic              rd_ack;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [5:0]        wr_bl;
    logic [6:0]        wr_count;
    logic              wr_ack;
    logic              cmd_full;
    logic              cmd_en;
    logic [2:0]        cmd_instr;
    logic [5:0]        cmd_bl;
    logic [ADDR_W-1:0] cmd_byte_addr;
    logic [3:0]        starve_cnt;
    modport slave (
        input  calib_done, rd_req, rd_addr, rd_bl, wr_req, wr_addr, wr_bl, wr_count, cmd_full,
        output rd_ack, wr_ack, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, starve_cnt
    );
    modport master (
        output calib_done, rd_req, rd_addr, rd_bl, wr_req, wr_addr, wr_bl, wr_count, cmd_full,
        input  rd_ack, wr_ack, cmd_en, cmd_instr, cmd_bl, cmd_byte_addr, starve_cnt
    );
endinterface

// File: rtl/vram_port_arbiter.sv
// vram_port_arbiter: shares one DDR2 command port between a priority read requester and a write requester.
//   clk    system clock, rising edge
//   reset  synchronous active-high reset
//   bus    vram_port_arbiter_if.slave: requester handshakes, command port, starve_cnt debug
//   Params: ADDR_W command byte-address width, STARVE_LIMIT max read grants while a write waits.
module vram_port_arbiter #(
    parameter int ADDR_W       = 30,
    parameter int STARVE_LIMIT = 4
) (
    input logic clk,
    input logic reset,
    vram_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {CAL, ARB, ISSUE, GAP} state_t;
    state_t            state;
    logic              sel_wr;
    logic              inc_pend;
    logic [2:0]        instr;
    logic [5:0]        bl;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        starve;
    logic              rd_elig;
    logic              wr_elig;
    logic              pick_wr;
    logic              fire;
    assign rd_elig = bus.rd_req;
    // Write only becomes eligible once its whole burst is already in the data FIFO.
    assign wr_elig = bus.wr_req && (({1'b0, bus.wr_bl} + 7'd1) <= bus.wr_count);
    assign pick_wr = wr_elig && (!rd_elig || starve == 4'(STARVE_LIMIT));
    // Gated by reset so a reset landing in ISSUE never emits a command.
    assign fire = (state == ISSUE) && !bus.cmd_full && !reset;
    assign bus.cmd_en        = fire;
    assign bus.rd_ack        = fire && !sel_wr;
    assign bus.wr_ack        = fire && sel_wr;
    assign bus.cmd_instr     = instr;
    assign bus.cmd_bl        = bl;
    assign bus.cmd_byte_addr = addr;
    assign bus.starve_cnt    = starve;
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= CAL;
            sel_wr   <= 1'b0;
            inc_pend <= 1'b0;
            instr    <= 3'b000;
            bl       <= 6'd0;
            addr     <= '0;
            starve   <= 4'd0;
        end else if (!bus.calib_done) begin
            // Losing calibration discards any pending selection; the requester still holds req.
            state  <= CAL;
            starve <= 4'd0;
        end else begin
            case (state)
                CAL: state <= ARB;
                ARB: begin
                    if (!bus.wr_req) starve <= 4'd0;
                    if (rd_elig || wr_elig) begin
                        state    <= ISSUE;
                        sel_wr   <= pick_wr;
                        inc_pend <= wr_elig;
                        instr    <= pick_wr ? 3'b000 : 3'b001;
                        bl       <= pick_wr ? bus.wr_bl : bus.rd_bl;
                        addr     <= pick_wr ? bus.wr_addr : bus.rd_addr;
                    end
                end
                ISSUE: begin
                    if (!bus.cmd_full) begin
                        state <= GAP;
                        if (sel_wr) starve <= 4'd0;
                        else if (inc_pend && starve != 4'(STARVE_LIMIT)) starve <= starve + 4'd1;
                    end
                end
                default: state <= ARB;
            endcase
        end
    end
endmodule

// File: tb/tb_vram_port_arbiter.sv
// tb_vram_port_arbiter: directed scoreboard bench for vram_port_arbiter.
module tb_vram_port_arbiter;
    typedef struct packed {
        logic [2:0]  instr;
        logic [5:0]  bl;
        logic [29:0] addr;
    } cmd_t;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    cmd_t q[$];
    logic       s_en, s_rd, s_wr;
    logic [2:0] s_instr;
    logic [5:0] s_bl;
    logic [29:0] s_addr;
    logic [3:0] s_starve;
    vram_port_arbiter_if #(.ADDR_W(30)) bus();
    vram_port_arbiter #(.ADDR_W(30), .STARVE_LIMIT(4)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic push(input logic [2:0] i, input logic [5:0] b, input logic [29:0] a);
        cmd_t c;
        c.instr = i;
        c.bl    = b;
        c.addr  = a;
        q.push_back(c);
    endtask
    // Samples outputs mid-cycle, checks every issued command against the scoreboard, then advances one cycle.
    task automatic step();
        cmd_t e;
        @(negedge clk);
        s_en = bus.cmd_en;
        s_rd = bus.rd_ack;
        s_wr = bus.wr_ack;
        s_instr = bus.cmd_instr;
        s_bl = bus.cmd_bl;
        s_addr = bus.cmd_byte_addr;
        s_starve = bus.starve_cnt;
        chk("en_eq_acks", 64'(s_en), 64'(s_rd | s_wr));
        chk("acks_excl", 64'(s_rd & s_wr), 64'd0);
        chk("sb_unexpected_cmd", 64'(s_en && q.size() == 0), 64'd0);
        if (s_en && q.size() > 0) begin
            e = q.pop_front();
            chk("sb_instr", 64'(s_instr), 64'(e.instr));
            chk("sb_bl", 64'(s_bl), 64'(e.bl));
            chk("sb_addr", 64'(s_addr), 64'(e.addr));
            chk("sb_ack_kind", 64'(s_wr), 64'(e.instr == 3'b000));
        end
        @(posedge clk);
        #1;
    endtask
    task automatic wait_ack(input string tag, input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!s_en && n < budget);
        chk(tag, 64'(s_en), 64'd1);
    endtask
    task automatic chk_zero(input string tag);
        chk({tag, "_en"}, 64'(s_en), 64'd0);
        chk({tag, "_instr"}, 64'(s_instr), 64'd0);
        chk({tag, "_bl"}, 64'(s_bl), 64'd0);
        chk({tag, "_addr"}, 64'(s_addr), 64'd0);
        chk({tag, "_starve"}, 64'(s_starve), 64'd0);
    endtask
    initial begin
        logic [9:0]  grant_wr;
        logic [39:0] starve_exp;
        total = 0;
        bad = 0;
        reset = 1'b1;
        bus.calib_done = 1'b0;
        bus.rd_req = 1'b0;
        bus.rd_addr = '0;
        bus.rd_bl = '0;
        bus.wr_req = 1'b0;
        bus.wr_addr = '0;
        bus.wr_bl = '0;
        bus.wr_count = '0;
        bus.cmd_full = 1'b0;
        // Reset state
        step();
        step();
        chk_zero("reset");
        reset = 1'b0;
        repeat (3) step();
        // First read after calibration: two cycles CAL->ARB->ISSUE
        bus.calib_done = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_addr = 30'h100;
        bus.rd_bl = 6'd15;
        push(3'b001, 6'd15, 30'h100);
        step();
        chk("t1_cal_en", 64'(s_en), 64'd0);
        step();
        chk("t1_arb_en", 64'(s_en), 64'd0);
        step();
        chk("t1_issue_en", 64'(s_en), 64'd1);
        chk("t1_rd_ack", 64'(s_rd), 64'd1);
        bus.rd_req = 1'b0;
        step();
        // Write waits until its 32-word burst is in the FIFO
        bus.wr_req = 1'b1;
        bus.wr_addr = 30'h2000;
        bus.wr_bl = 6'd31;
        push(3'b000, 6'd31, 30'h2000);
        for (int k = 0; k <= 32; k++) begin
            bus.wr_count = 7'(k);
            step();
            chk("t2_early_en", 64'(s_en), 64'd0);
        end
        step();
        chk("t2_wr_en", 64'(s_en), 64'd1);
        chk("t2_wr_ack", 64'(s_wr), 64'd1);
        bus.wr_req = 1'b0;
        bus.wr_count = 7'd0;
        step();
        // Starvation: continuous read plus eligible write
        bus.rd_req = 1'b1;
        bus.rd_addr = 30'h300;
        bus.rd_bl = 6'd7;
        bus.wr_req = 1'b1;
        bus.wr_addr = 30'h400;
        bus.wr_bl = 6'd3;
        bus.wr_count = 7'd4;
        grant_wr = 10'b1000010000;
        starve_exp = {4'd0, 4'd4, 4'd3, 4'd2, 4'd1, 4'd0, 4'd4, 4'd3, 4'd2, 4'd1};
        for (int g = 0; g < 10; g++) begin
            if (grant_wr[g]) push(3'b000, 6'd3, 30'h400);
            else push(3'b001, 6'd7, 30'h300);
        end
        for (int g = 0; g < 10; g++) begin
            wait_ack("t3_ack_timeout", 4);
            chk("t3_grant_wr", 64'(s_wr), 64'(grant_wr[g]));
            step();
            chk("t3_starve", 64'(s_starve), 64'(starve_exp[g*4 +: 4]));
        end
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b0;
        step();
        // Command FIFO full holds ISSUE with stable fields
        bus.rd_req = 1'b1;
        bus.rd_addr = 30'h500;
        bus.rd_bl = 6'd2;
        bus.cmd_full = 1'b1;
        push(3'b001, 6'd2, 30'h500);
        step();
        bus.rd_addr = 30'h5A5;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("t4_full_en", 64'(s_en), 64'd0);
            chk("t4_full_bl", 64'(s_bl), 64'd2);
            chk("t4_full_addr", 64'(s_addr), 64'h500);
        end
        bus.cmd_full = 1'b0;
        step();
        chk("t4_release_en", 64'(s_en), 64'd1);
        chk("t4_release_rd_ack", 64'(s_rd), 64'd1);
        bus.rd_req = 1'b0;
        step();
        // Calibration lost during ISSUE discards the selection
        bus.rd_req = 1'b1;
        bus.rd_addr = 30'h600;
        bus.rd_bl = 6'd4;
        bus.cmd_full = 1'b1;
        step();
        bus.calib_done = 1'b0;
        step();
        chk("t5_drop_en", 64'(s_en), 64'd0);
        bus.cmd_full = 1'b0;
        step();
        chk("t5_cal_en", 64'(s_en), 64'd0);
        chk("t5_cal_rd_ack", 64'(s_rd), 64'd0);
        step();
        chk("t5_cal2_en", 64'(s_en), 64'd0);
        bus.calib_done = 1'b1;
        push(3'b001, 6'd4, 30'h600);
        step();
        chk("t5_recal_en", 64'(s_en), 64'd0);
        step();
        chk("t5_arb_en", 64'(s_en), 64'd0);
        step();
        chk("t5_reissue_en", 64'(s_en), 64'd1);
        bus.rd_req = 1'b0;
        repeat (3) step();
        chk("t5_once", 64'(q.size()), 64'd0);
        // Reset asserted in the ISSUE cycle
        bus.rd_req = 1'b1;
        bus.rd_addr = 30'h700;
        bus.rd_bl = 6'd9;
        step();
        reset = 1'b1;
        bus.calib_done = 1'b0;
        step();
        chk("t6_reset_cycle_en", 64'(s_en), 64'd0);
        chk("t6_reset_cycle_ack", 64'(s_rd), 64'd0);
        reset = 1'b0;
        step();
        chk_zero("t6_after_reset");
        step();
        chk("t6_nocal_en", 64'(s_en), 64'd0);
        bus.calib_done = 1'b1;
        push(3'b001, 6'd9, 30'h700);
        step();
        step();
        chk("t6_arb_en", 64'(s_en), 64'd0);
        step();
        chk("t6_reissue_en", 64'(s_en), 64'd1);
        bus.rd_req = 1'b0;
        repeat (2) step();
        chk("sb_drained", 64'(q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
